// File: rtl/pps_capture_pkg.sv
// Shared constants, timestamp layout and latency-compensation arithmetic for the
// PPS capture path.
package pps_capture_pkg;

    localparam int SEC_W = 48;
    localparam int NS_W  = 32;
    localparam int TS_W  = SEC_W + NS_W;
    localparam int CYC_W = 28;
    localparam int CMP_W = 16;

    localparam logic [NS_W-1:0]  NS_PER_SEC = 32'd1_000_000_000;
    localparam logic [CYC_W-1:0] CYC_MAX    = '1;

    typedef struct packed {
        logic [SEC_W-1:0] sec;
        logic [NS_W-1:0]  ns;
    } ts_t;

    // Moves a timestamp back by cmp ns, borrowing one second when ns would underflow.
    function automatic ts_t compensate(input ts_t ts, input logic [CMP_W-1:0] cmp);
        ts_t             res;
        logic [NS_W-1:0] cmpNs;
        cmpNs = NS_W'(cmp);
        if (ts.ns >= cmpNs) begin
            res.sec = ts.sec;
            res.ns  = ts.ns - cmpNs;
        end else begin
            res.sec = ts.sec - SEC_W'(1);
            res.ns  = ts.ns + NS_PER_SEC - cmpNs;
        end
        return res;
    endfunction

endpackage

// File: rtl/pps_capture_if.sv
// Control/status bundle between the PPS capture block (slave) and the RTC
// register block (master).
interface pps_capture_if #(
    parameter int FIFO_DEPTH = 4
);
    import pps_capture_pkg::*;

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic              pps_i;
    logic [TS_W-1:0]   rtc_std_i;
    logic              enable_i;
    logic [CMP_W-1:0]  cmp_ns_i;
    logic              pop_i;
    logic              clr_i;
    logic              edge_o;
    logic [TS_W-1:0]   ts_o;
    logic              ts_valid_o;
    logic [CNT_W-1:0]  fifo_cnt_o;
    logic              ovf_o;
    logic [CYC_W-1:0]  period_o;
    logic              los_o;

    modport slave (
        input  pps_i, rtc_std_i, enable_i, cmp_ns_i, pop_i, clr_i,
        output edge_o, ts_o, ts_valid_o, fifo_cnt_o, ovf_o, period_o, los_o
    );

    modport master (
        output pps_i, rtc_std_i, enable_i, cmp_ns_i, pop_i, clr_i,
        input  edge_o, ts_o, ts_valid_o, fifo_cnt_o, ovf_o, period_o, los_o
    );

endinterface

// File: rtl/pps_ts_fifo.sv
// Synchronous timestamp FIFO with occupancy count; a push into a full FIFO is
// only accepted when a pop frees a slot in the same cycle.
module pps_ts_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 80
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_clr,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_data,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_full,
    output logic                       o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wrPtr;
    logic [AW-1:0]    r_rdPtr;
    logic [CW-1:0]    r_count;
    logic             w_doPush;
    logic             w_doPop;

    assign o_full   = (r_count == CW'(DEPTH));
    assign o_empty  = (r_count == '0);
    assign w_doPop  = i_pop & ~o_empty;
    assign w_doPush = i_push & (~o_full | w_doPop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else if (i_clr) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) r_wrPtr <= r_wrPtr + AW'(1);
            if (w_doPop)  r_rdPtr <= r_rdPtr + AW'(1);
            if (w_doPush && !w_doPop)      r_count <= r_count + CW'(1);
            else if (w_doPop && !w_doPush) r_count <= r_count - CW'(1);
        end
    end

    // Storage carries no reset; the head output is masked while empty instead.
    always_ff @(posedge clk) begin
        if (w_doPush && !i_clr) r_mem[r_wrPtr] <= i_data;
    end

    assign o_data  = o_empty ? '0 : r_mem[r_rdPtr];
    assign o_count = r_count;

endmodule

// File: rtl/pps_capture.sv
// 1PPS input capture: synchronises pps_i, qualifies rising edges, measures the
// pulse period, flags loss of signal and queues compensated RTC timestamps.
module pps_capture
    import pps_capture_pkg::*;
#(
    parameter int               FIFO_DEPTH  = 4,
    parameter logic [CYC_W-1:0] MIN_CYC     = 28'd1_000_000,
    parameter logic [CYC_W-1:0] TIMEOUT_CYC = 28'd234_375_000
) (
    input  logic          rtc_clk,
    input  logic          rst,
    pps_capture_if.slave  bus
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic             r_s1, r_s2, r_s3;
    logic             r_edge;
    logic             r_first;
    logic [CYC_W-1:0] r_cycCnt;
    logic [CYC_W-1:0] r_period;
    logic             r_los;
    ts_t              r_comp;
    logic             r_pushPend;
    logic             r_ovf;
    logic             w_rise;
    logic             w_accept;
    logic [TS_W-1:0]  w_head;
    logic [CNT_W-1:0] w_count;
    logic             w_full;
    logic             w_empty;

    assign w_rise   = r_s2 & ~r_s3;
    assign w_accept = w_rise & bus.enable_i & (r_first | (r_cycCnt >= MIN_CYC));

    always_ff @(posedge rtc_clk or posedge rst) begin
        if (rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= bus.pps_i;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    // r_first stays set until the first accepted edge, so no period is reported from reset.
    always_ff @(posedge rtc_clk or posedge rst) begin
        if (rst) begin
            r_edge   <= 1'b0;
            r_first  <= 1'b1;
            r_cycCnt <= '0;
            r_period <= '0;
            r_los    <= 1'b0;
        end else begin
            r_edge <= w_accept;

            if (!bus.enable_i) r_first <= 1'b1;
            else if (r_edge)   r_first <= 1'b0;

            if (bus.clr_i || !bus.enable_i) r_cycCnt <= '0;
            else if (r_edge)                r_cycCnt <= CYC_W'(1);
            else if (r_cycCnt != CYC_MAX)   r_cycCnt <= r_cycCnt + CYC_W'(1);

            if (bus.clr_i) begin
                r_period <= '0;
                r_los    <= 1'b0;
            end else if (r_edge) begin
                if (!r_first) r_period <= r_cycCnt;
                r_los <= 1'b0;
            end else if (r_cycCnt == TIMEOUT_CYC) begin
                r_los <= 1'b1;
            end
        end
    end

    // Timestamp is compensated in the edge cycle and pushed one cycle later.
    always_ff @(posedge rtc_clk or posedge rst) begin
        if (rst) begin
            r_comp     <= '0;
            r_pushPend <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            r_pushPend <= r_edge;
            if (r_edge) r_comp <= compensate(bus.rtc_std_i, bus.cmp_ns_i);
            if (bus.clr_i)                                r_ovf <= 1'b0;
            else if (r_pushPend && w_full && !bus.pop_i)  r_ovf <= 1'b1;
        end
    end

    pps_ts_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (TS_W)
    ) u_fifo (
        .clk     (rtc_clk),
        .rst     (rst),
        .i_clr   (bus.clr_i),
        .i_push  (r_pushPend),
        .i_data  (r_comp),
        .i_pop   (bus.pop_i),
        .o_data  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign bus.edge_o     = r_edge;
    assign bus.ts_o       = w_head;
    assign bus.ts_valid_o = ~w_empty;
    assign bus.fifo_cnt_o = w_count;
    assign bus.ovf_o      = r_ovf;
    assign bus.period_o   = r_period;
    assign bus.los_o      = r_los;

endmodule
